// File: rtl/calc_request_master.sv
`default_nettype none
// ============================================================================
// Module   : calc_request_master
// Brief    : Queues calculator requests and issues them one at a time over
//            the go/done handshake, returning each result on a valid/ready port.
// Revision : 1.0
// ============================================================================
module calc_request_master #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = 31
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [1:0]                 i_req_op,
    input  logic [DATA_W-1:0]          i_req_a,
    input  logic [DATA_W-1:0]          i_req_b,
    output logic                       o_calc_go,
    output logic [1:0]                 o_calc_op,
    output logic [DATA_W-1:0]          o_calc_in1,
    output logic [DATA_W-1:0]          o_calc_in2,
    input  logic                       i_calc_done,
    input  logic [DATA_W-1:0]          i_calc_out,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [DATA_W-1:0]          o_rsp_data,
    output logic [1:0]                 o_rsp_op,
    output logic                       o_rsp_tmo,
    output logic                       o_busy,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_TW = $clog2(TIMEOUT);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);
    localparam logic [c_CW-1:0] c_FULL     = c_CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [1:0]        r_fifo_op [DEPTH];
    logic [DATA_W-1:0] r_fifo_a  [DEPTH];
    logic [DATA_W-1:0] r_fifo_b  [DEPTH];
    logic [c_PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic [c_TW-1:0]   r_timer;
    logic              r_done_q;
    logic [1:0]        r_calc_op;
    logic [DATA_W-1:0] r_calc_in1, r_calc_in2, r_rsp_data;
    logic [1:0]        r_rsp_op;
    logic              r_rsp_tmo;

    logic w_push, w_pop, w_latch, w_cap_done, w_cap_tmo, w_timer_clr, w_timer_inc;
    logic w_done_edge;

    assign o_req_ready = (r_count != c_FULL);
    assign w_push      = i_req_valid & o_req_ready;
    assign w_pop       = (r_state == S_RESP) & i_rsp_ready;
    // Only a fresh rising edge counts; a done level left over from a prior op is ignored.
    assign w_done_edge = i_calc_done & ~r_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_cap_done  = 1'b0;
        w_cap_tmo   = 1'b0;
        w_timer_clr = 1'b0;
        w_timer_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_timer_clr = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_done_edge) begin
                    w_cap_done  = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_timer == c_TMO_LAST) begin
                    w_cap_tmo   = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr] <= i_req_op;
            r_fifo_a[r_wr_ptr]  <= i_req_a;
            r_fifo_b[r_wr_ptr]  <= i_req_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_done_q <= 1'b0;
            r_timer  <= '0;
        end else begin
            r_done_q <= i_calc_done;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
            if (w_push & ~w_pop)      r_count <= r_count + c_CW'(1);
            else if (~w_push & w_pop) r_count <= r_count - c_CW'(1);
            if (w_timer_clr)      r_timer <= '0;
            else if (w_timer_inc) r_timer <= r_timer + c_TW'(1);
        end
    end

    // Head stays in the FIFO while in flight; operands are copied out so they hold through WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_calc_op  <= '0;
            r_calc_in1 <= '0;
            r_calc_in2 <= '0;
            r_rsp_data <= '0;
            r_rsp_op   <= '0;
            r_rsp_tmo  <= 1'b0;
        end else begin
            if (w_latch) begin
                r_calc_op  <= r_fifo_op[r_rd_ptr];
                r_calc_in1 <= r_fifo_a[r_rd_ptr];
                r_calc_in2 <= r_fifo_b[r_rd_ptr];
            end
            if (w_cap_done | w_cap_tmo) begin
                r_rsp_data <= w_cap_done ? i_calc_out : '0;
                r_rsp_op   <= r_calc_op;
                r_rsp_tmo  <= w_cap_tmo;
            end
        end
    end

    assign o_calc_go   = (r_state == S_LAUNCH);
    assign o_calc_op   = r_calc_op;
    assign o_calc_in1  = r_calc_in1;
    assign o_calc_in2  = r_calc_in2;
    assign o_rsp_valid = (r_state == S_RESP);
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_op    = r_rsp_op;
    assign o_rsp_tmo   = r_rsp_tmo;
    assign o_busy      = (r_state != S_IDLE);
    assign o_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_calc_request_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_request_master
// Brief    : Scoreboard bench for calc_request_master with a behavioural calculator.
// Revision : 1.0
// ============================================================================
module tb_calc_request_master;

    localparam int DEPTH = 4, DATA_W = 4, TIMEOUT = 31;

    logic clk = 1'b0;
    logic rst;
    logic req_valid, req_ready, calc_go, calc_done, rsp_valid, rsp_ready, rsp_tmo, busy;
    logic [1:0] req_op, calc_op, rsp_op;
    logic [DATA_W-1:0] req_a, req_b, calc_in1, calc_in2, calc_out, rsp_data;
    logic [2:0] count;

    calc_request_master #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b),
        .o_calc_go(calc_go), .o_calc_op(calc_op), .o_calc_in1(calc_in1), .o_calc_in2(calc_in2),
        .i_calc_done(calc_done), .i_calc_out(calc_out),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_op(rsp_op), .o_rsp_tmo(rsp_tmo),
        .o_busy(busy), .o_count(count)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        op;
        logic              tmo;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Calculator model: mode 0 = pulse done, 1 = never done, 2 = level done
    // (held until one cycle after the next go).
    int mode = 0, delay = 4, cnt = 0, go_cyc = 0, go_count = 0;
    logic drop = 1'b0;
    logic [1:0] m_op;
    logic [DATA_W-1:0] m_a, m_b;

    function automatic logic [DATA_W-1:0] calc(input logic [1:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    initial begin
        calc_done = 1'b0;
        calc_out  = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                cnt = 0; drop = 1'b0; calc_done = 1'b0;
            end else if (calc_go) begin
                m_op = calc_op; m_a = calc_in1; m_b = calc_in2;
                cnt = delay; go_cyc = cyc; go_count++;
                if (mode == 2) drop = 1'b1;
                else calc_done = 1'b0;
            end else begin
                if (drop) begin calc_done = 1'b0; drop = 1'b0; end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0 && mode != 1) begin
                        calc_done = 1'b1;
                        calc_out  = calc(m_op, m_a, m_b);
                    end
                end else if (mode == 0) begin
                    calc_done = 1'b0;
                end
            end
        end
    end

    // Response-ready driver: 0 = low, 1 = high, 2 = random.
    int rmode = 0;
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks hold stability.
    int rise_cyc = 0;
    logic prev_valid = 1'b0, hold = 1'b0;
    exp_t held, e;
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid && !prev_valid) rise_cyc = cyc;
            if (hold && rsp_valid) begin
                chk("hold_data", int'(rsp_data), int'(held.data));
                chk("hold_op", int'(rsp_op), int'(held.op));
                chk("hold_tmo", int'(rsp_tmo), int'(held.tmo));
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_data", int'(rsp_data), int'(e.data));
                    chk("rsp_op", int'(rsp_op), int'(e.op));
                    chk("rsp_tmo", int'(rsp_tmo), int'(e.tmo));
                end
                hold = 1'b0;
            end else if (rsp_valid) begin
                hold = 1'b1;
                held = '{data: rsp_data, op: rsp_op, tmo: rsp_tmo};
            end else begin
                hold = 1'b0;
            end
            prev_valid = rsp_valid;
        end
    end

    int acc_cyc = 0;
    task automatic send(input logic [1:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [DATA_W-1:0] edata, input logic etmo);
        int waited = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(negedge clk);
        while (!req_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 300) begin
            chk("req_accept_timeout", 0, 1);
        end else begin
            sb.push_back('{data: edata, op: op, tmo: etmo});
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int waited = 0;
        @(negedge clk);
        while (!(sb.size() == 0 && !busy && count == 0) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 500) begin
            chk(name, 0, 1);
            sb.delete();
        end
    endtask

    int seen;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        #12;
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_calc_go", int'(calc_go), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        @(negedge clk); rst = 1'b0;

        // 1: single request, done 4 cycles after go
        mode = 0; delay = 4; rmode = 1; go_count = 0;
        send(2'd0, 4'd3, 4'd5, 4'd8, 1'b0);
        drain("t1_drain");
        chk("t1_go_latency", go_cyc - acc_cyc + 1, 2);      // go high at edge N+2
        chk("t1_go_pulses", go_count, 1);
        chk("t1_rsp_latency", rise_cyc - go_cyc, 5);

        // 2: fill the FIFO with responses stalled
        rmode = 0;
        send(2'd0, 4'd1, 4'd1, 4'd2, 1'b0);
        send(2'd1, 4'd8, 4'd3, 4'd5, 1'b0);
        send(2'd2, 4'd15, 4'd9, 4'd9, 1'b0);
        send(2'd3, 4'd5, 4'd12, 4'd9, 1'b0);
        chk("t2_count_full", int'(count), 4);
        chk("t2_ready_full", int'(req_ready), 0);
        fork
            send(2'd0, 4'd7, 4'd7, 4'd14, 1'b0);
            begin
                repeat (6) @(negedge clk);
                chk("t2_ready_stalled", int'(req_ready), 0);
                chk("t2_count_stalled", int'(count), 4);
                rmode = 1;
            end
        join
        drain("t2_drain");

        // 3: calculator never completes
        mode = 1;
        send(2'd1, 4'd4, 4'd4, 4'd0, 1'b1);
        drain("t3_drain_a");
        chk("t3_tmo_latency", rise_cyc - go_cyc, TIMEOUT + 1);
        send(2'd2, 4'd9, 4'd3, 4'd0, 1'b1);
        drain("t3_drain_b");

        // 4: level-style done held across ops
        mode = 2; delay = 4;
        send(2'd0, 4'd2, 4'd2, 4'd4, 1'b0);
        send(2'd3, 4'd15, 4'd0, 4'd15, 1'b0);
        send(2'd2, 4'd6, 4'd6, 4'd6, 1'b0);
        drain("t4_drain");

        // 6: random response backpressure, ops cycling
        mode = 0; delay = 2; rmode = 2;
        send(2'd0, 4'd1, 4'd2, 4'd3, 1'b0);
        send(2'd1, 4'd9, 4'd4, 4'd5, 1'b0);
        send(2'd2, 4'd12, 4'd10, 4'd8, 1'b0);
        send(2'd3, 4'd6, 4'd3, 4'd5, 1'b0);
        send(2'd0, 4'd15, 4'd1, 4'd0, 1'b0);
        send(2'd1, 4'd2, 4'd5, 4'd13, 1'b0);
        send(2'd2, 4'd7, 4'd14, 4'd6, 1'b0);
        send(2'd3, 4'd10, 4'd10, 4'd0, 1'b0);
        drain("t6_drain");

        // 5: reset while waiting with two entries queued
        mode = 1; rmode = 1;
        send(2'd0, 4'd1, 4'd1, 4'd0, 1'b1);
        send(2'd1, 4'd2, 4'd2, 4'd0, 1'b1);
        repeat (4) @(negedge clk);
        chk("t5_pre_busy", int'(busy), 1);
        chk("t5_pre_count", int'(count), 2);
        #2 rst = 1'b1;
        #1;
        chk("t5_go", int'(calc_go), 0);
        chk("t5_rsp_valid", int'(rsp_valid), 0);
        chk("t5_count", int'(count), 0);
        chk("t5_req_ready", int'(req_ready), 1);
        sb.delete();
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (rsp_valid || calc_go || busy) seen++;
        end
        chk("t5_quiet_after_reset", seen, 0);
        chk("t5_count_after", int'(count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
